// File: rtl/linebuffer_pkg.sv
// linebuffer_pkg: counter width and tap index helpers for the 2D line buffer
package linebuffer_pkg;
  localparam int CNT_MIN_W = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < CNT_MIN_W) ? CNT_MIN_W : r;
  endfunction
  function automatic int tap_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction
endpackage

// File: rtl/lb_row_delay.sv
// lb_row_delay: one image row of delay, read-before-write at a shared address
module lb_row_delay import linebuffer_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  assign dout = r_mem[addr];
  always_ff @(posedge clk)
    if (wen) r_mem[addr] <= din;
endmodule

// File: rtl/linebuffer_2d.sv
// linebuffer_2d: ROWS x COLS stencil window over a row-major pixel stream.
// Defining LB_FRAME_COUNT_EN adds frame_done and restarts counters every IMG_H rows.
module linebuffer_2d import linebuffer_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int IMG_W = 64,
  parameter int ROWS  = 3,
  parameter int COLS  = 3,
  parameter int IMG_H = 64
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        wen,
  input  logic [WIDTH-1:0]            in,
  output logic [ROWS*COLS*WIDTH-1:0]  out,
`ifdef LB_FRAME_COUNT_EN
  output logic                        frame_done,
`endif
  output logic                        valid
);
  localparam int CW = clog2(IMG_W);
  localparam int RW = clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic             w_wrap;
  logic             w_done;
  logic [WIDTH-1:0] w_col [ROWS];
  if (IMG_W < COLS || ROWS < 1 || COLS < 1 || IMG_H < 1) begin : g_bad_cfg
    $error("linebuffer_2d: invalid geometry");
  end
  assign w_wrap = r_col == COL_LAST;
  assign valid = wen && r_row == ROW_LAST && r_col >= COL_FIRST;
  assign w_col[ROWS-1] = in;
`ifdef LB_FRAME_COUNT_EN
  localparam int FW = clog2(IMG_H);
  localparam logic [FW-1:0] FRM_LAST = FW'(IMG_H - 1);
  logic [FW-1:0] r_frm;
  assign w_done = wen && w_wrap && r_frm == FRM_LAST;
  assign frame_done = w_done;
  always_ff @(posedge clk or posedge arst)
    if (arst) r_frm <= '0;
    else if (wen) r_frm <= w_done ? '0 : w_wrap ? r_frm + 1'b1 : r_frm;
`else
  assign w_done = 1'b0;
`endif
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (wen) begin
      r_col <= (w_wrap || w_done) ? '0 : r_col + 1'b1;
      r_row <= w_done ? '0 : (w_wrap && r_row != ROW_LAST) ? r_row + 1'b1 : r_row;
    end
  // Row r of the live column is the pixel from ROWS-1-r rows ago
  for (genvar r = 0; r < ROWS - 1; r++) begin : g_dly
    lb_row_delay #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_dly (
      .clk  (clk),
      .wen  (wen),
      .addr (r_col),
      .din  (w_col[r+1]),
      .dout (w_col[r])
    );
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_tap
      localparam int LSB = tap_idx(r, c, COLS) * WIDTH;
      if (c == COLS - 1) begin : g_live
        assign out[LSB +: WIDTH] = w_col[r];
      end else begin : g_reg
        logic [WIDTH-1:0] r_tap;
        always_ff @(posedge clk or posedge arst)
          if (arst) r_tap <= '0;
          else if (wen) r_tap <= out[LSB + WIDTH +: WIDTH];
        assign out[LSB +: WIDTH] = r_tap;
      end
    end
  end
endmodule

// File: tb/tb_linebuffer_2d.sv
// tb_linebuffer_2d: 2x2 window on a 4-wide image plus a legacy 1x2 instance
module tb_linebuffer_2d;
  logic        clk = 1'b0;
  logic        arst, wen, l_wen;
  logic [15:0] in, l_in;
  logic [63:0] out;
  logic [31:0] l_out;
  logic        valid, l_valid;
`ifdef LB_FRAME_COUNT_EN
  logic        fd, l_fd;
  localparam bit FRAME = 1'b1;
`else
  localparam bit FRAME = 1'b0;
`endif
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  linebuffer_2d #(.WIDTH(16), .IMG_W(4), .ROWS(2), .COLS(2), .IMG_H(3)) u_dut (
    .clk   (clk),
    .arst  (arst),
    .wen   (wen),
    .in    (in),
    .out   (out),
`ifdef LB_FRAME_COUNT_EN
    .frame_done (fd),
`endif
    .valid (valid)
  );

  linebuffer_2d #(.WIDTH(16), .IMG_W(8), .ROWS(1), .COLS(2)) u_leg (
    .clk   (clk),
    .arst  (arst),
    .wen   (l_wen),
    .in    (l_in),
    .out   (l_out),
`ifdef LB_FRAME_COUNT_EN
    .frame_done (l_fd),
`endif
    .valid (l_valid)
  );

  typedef struct {
    logic             ar;
    logic             wen;
    logic [15:0]      pix;
    logic             ev;
    logic             fd;
    logic [3:0]       m;
    logic [3:0][15:0] w;
    string            nm;
  } vec_t;

  vec_t sbq[$];
  vec_t tbl[10];

  function automatic vec_t mk(input logic ar, input logic we, input logic [15:0] pix,
                              input logic ev, input logic fd, input logic [3:0] m,
                              input logic [15:0] w00, input logic [15:0] w01,
                              input logic [15:0] w10, input string nm);
    vec_t v;
    v.ar = ar; v.wen = we; v.pix = pix; v.ev = ev; v.fd = fd; v.m = m;
    v.w = {pix, w10, w01, w00};
    v.nm = nm;
    return v;
  endfunction

  // Pixel p of a stream whose values equal p, at position q within its frame
  function automatic vec_t px(input int p, input int q, input logic fd);
    logic ev;
    ev = q >= 4 && q % 4 != 0;
    return mk(1'b0, 1'b1, 16'(p), ev, fd, ev ? 4'h7 : 4'h0,
              16'(p - 5), 16'(p - 4), 16'(p - 1), $sformatf("f%0d", p));
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_out();
    vec_t e;
    if (sbq.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sbq.pop_front();
    chk({e.nm, "_valid"}, 16'(valid), 16'(e.ev));
    chk({e.nm, "_t11"}, out[63:48], e.w[3]);
    for (int i = 0; i < 3; i++)
      if (e.m[i]) chk($sformatf("%s_t%0d", e.nm, i), out[i*16 +: 16], e.w[i]);
`ifdef LB_FRAME_COUNT_EN
    chk({e.nm, "_fd"}, 16'(fd), 16'(e.fd));
`endif
  endtask

  task automatic apply(input vec_t v);
    arst = v.ar;
    wen = v.wen;
    in = v.pix;
    sbq.push_back(v);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1 arst = 1'b0;
  endtask

  task automatic do_reset();
    apply(mk(1'b1, 1'b0, 16'hABCD, 1'b0, 1'b0, 4'b0101, 16'h0, 16'h0, 16'h0, "rst"));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, "p0");
    tbl[1] = mk(0, 1, 1, 0, 0, 4'h0, 0, 0, 0, "p1");
    tbl[2] = mk(0, 1, 2, 0, 0, 4'h0, 0, 0, 0, "p2");
    tbl[3] = mk(0, 1, 3, 0, 0, 4'h0, 0, 0, 0, "p3");
    tbl[4] = mk(0, 1, 4, 0, 0, 4'h2, 0, 0, 0, "p4");
    tbl[5] = mk(0, 1, 5, 1, 0, 4'h7, 0, 1, 4, "p5");
    tbl[6] = mk(0, 1, 6, 1, 0, 4'h7, 1, 2, 5, "p6");
    tbl[7] = mk(0, 1, 7, 1, 0, 4'h7, 2, 3, 6, "p7");
    tbl[8] = mk(0, 1, 8, 0, 0, 4'h7, 3, 4, 7, "p8");
    tbl[9] = mk(0, 1, 9, 1, 0, 4'h7, 4, 5, 8, "p9");
    arst = 1'b1; wen = 1'b0; l_wen = 1'b0; in = '0; l_in = '0;
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 10; i++) apply(tbl[i]);
    do_reset();
    for (int i = 0; i < 7; i++) apply(tbl[i]);
    for (int i = 0; i < 3; i++) apply(mk(0, 0, 16'hFFFF, 0, 0, 4'h7, 2, 3, 6, "stall"));
    for (int i = 7; i < 10; i++) apply(tbl[i]);
    do_reset();
    for (int i = 0; i < 6; i++) apply(tbl[i]);
    apply(mk(1, 1, 6, 0, 0, 4'h7, 0, 4, 0, "arst_mid"));
    for (int i = 0; i < 6; i++) apply(tbl[i]);
    do_reset();
    for (int p = 0; p < 18; p++)
      apply(px(p, FRAME ? p % 12 : p, FRAME && p == 11));
    do_reset();
    for (int k = 0; k < 9; k++) begin
      l_wen = 1'b1;
      l_in = 16'(10 + k);
      @(negedge clk);
      chk($sformatf("leg%0d_in", k), l_out[31:16], l_in);
      chk($sformatf("leg%0d_valid", k), 16'(l_valid), 16'(k % 8 != 0));
      if (k > 0) chk($sformatf("leg%0d_prev", k), l_out[15:0], 16'(9 + k));
      @(posedge clk);
      #1;
    end
    l_wen = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
